// File: rtl/pi_word_mux.sv
// Word steering element of the deflection pi-switch. It selects one of 2, 3 or 4 W-bit
// packet words using a binary select. An output register stage is optional.
module pi_word_mux #(
    parameter int unsigned W   = 32,
    parameter int unsigned N   = 4,
    parameter bit          REG = 1'b0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [1:0]   s,
    input  logic [W-1:0] i0,
    input  logic [W-1:0] i1,
    input  logic [W-1:0] i2,
    input  logic [W-1:0] i3,
    output logic [W-1:0] o
);

    logic [W-1:0] o_d;

    // Some ports are unused in certain builds, such as i2/i3 in the lean forms or
    // clk/rst in the combinational build. This signal gathers them so the lint
    // check does not report them.
    logic unused_ok;
    assign unused_ok = ^{clk, rst, s, i0, i1, i2, i3};

    // These ternary trees propagate an X on the select. A known select never
    // passes through anything from an unselected input.
    generate
        if (N == 4) begin : g_n4
            always_comb begin
                o_d = s[1] ? (s[0] ? i3 : i2) : (s[0] ? i1 : i0);
            end
        end else if (N == 3) begin : g_n3
            // s[1] dominates. The lean switch drives s=3, and that value must pick i2.
            always_comb begin
                o_d = s[1] ? i2 : (s[0] ? i1 : i0);
            end
        end else if (N == 2) begin : g_n2
            always_comb begin
                o_d = s[0] ? i1 : i0;
            end
        end else begin : g_bad_n
            $error("pi_word_mux: N must be 2, 3 or 4");
            always_comb begin
                o_d = '0;
            end
        end
    endgenerate

    generate
        if (REG) begin : g_reg
            logic [W-1:0] o_q;

            always_ff @(posedge clk) begin
                if (rst) begin
                    o_q <= '0;
                end else begin
                    o_q <= o_d;
                end
            end

            assign o = o_q;
        end else begin : g_comb
            assign o = o_d;
        end
    endgenerate

endmodule

// File: tb/tb_pi_word_mux.sv
// Directed and randomized checks of pi_word_mux. The bench exercises N=2/3/4
// in combinational and registered builds, and a 38-bit datapath.
module tb_pi_word_mux;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  s   = 2'd0;
    logic [7:0]  a0 = '0, a1 = '0, a2 = '0, a3 = '0;
    logic [7:0]  o_c4, o_c3, o_c2, o_r4, o_r3, o_r2;
    logic [1:0]  ws = 2'd0;
    logic [37:0] w0 = '0, w1 = '0, w2 = '0, w3 = '0;
    logic [37:0] o_w;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    pi_word_mux #(.W(8), .N(4), .REG(1'b0)) u_c4 (.clk(clk), .rst(rst), .s(s), .i0(a0), .i1(a1), .i2(a2), .i3(a3), .o(o_c4));
    pi_word_mux #(.W(8), .N(3), .REG(1'b0)) u_c3 (.clk(clk), .rst(rst), .s(s), .i0(a0), .i1(a1), .i2(a2), .i3(a3), .o(o_c3));
    pi_word_mux #(.W(8), .N(2), .REG(1'b0)) u_c2 (.clk(clk), .rst(rst), .s(s), .i0(a0), .i1(a1), .i2(a2), .i3(a3), .o(o_c2));
    pi_word_mux #(.W(8), .N(4), .REG(1'b1)) u_r4 (.clk(clk), .rst(rst), .s(s), .i0(a0), .i1(a1), .i2(a2), .i3(a3), .o(o_r4));
    pi_word_mux #(.W(8), .N(3), .REG(1'b1)) u_r3 (.clk(clk), .rst(rst), .s(s), .i0(a0), .i1(a1), .i2(a2), .i3(a3), .o(o_r3));
    pi_word_mux #(.W(8), .N(2), .REG(1'b1)) u_r2 (.clk(clk), .rst(rst), .s(s), .i0(a0), .i1(a1), .i2(a2), .i3(a3), .o(o_r2));
    pi_word_mux #(.W(38), .N(4), .REG(1'b0)) u_w (.clk(clk), .rst(rst), .s(ws), .i0(w0), .i1(w1), .i2(w2), .i3(w3), .o(o_w));

    // Reference selection rules, written as per-N lookup tables.
    function automatic logic [7:0] model(input int n, input logic [1:0] sel,
                                         input logic [7:0] x0, input logic [7:0] x1,
                                         input logic [7:0] x2, input logic [7:0] x3);
        case (n)
            2: begin
                case (sel)
                    2'd0, 2'd2: return x0;
                    default:    return x1;
                endcase
            end
            3: begin
                case (sel)
                    2'd0:    return x0;
                    2'd1:    return x1;
                    default: return x2;
                endcase
            end
            default: begin
                case (sel)
                    2'd0:    return x0;
                    2'd1:    return x1;
                    2'd2:    return x2;
                    default: return x3;
                endcase
            end
        endcase
    endfunction

    task automatic check(input string name, input logic [37:0] act, input logic [37:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        int         n;
        logic [1:0] s;
        logic [7:0] i0, i1, i2, i3;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs[14];

    function automatic logic [7:0] comb_out(input int n);
        case (n)
            2:       return o_c2;
            3:       return o_c3;
            default: return o_c4;
        endcase
    endfunction

    initial begin
        logic [7:0]  exp_r4, exp_r3, exp_r2;
        logic [37:0] one;

        vecs[0]  = '{4, 2'd0, 8'h11, 8'h22, 8'h33, 8'h44, 8'h11};
        vecs[1]  = '{4, 2'd1, 8'h11, 8'h22, 8'h33, 8'h44, 8'h22};
        vecs[2]  = '{4, 2'd2, 8'h11, 8'h22, 8'h33, 8'h44, 8'h33};
        vecs[3]  = '{4, 2'd3, 8'h11, 8'h22, 8'h33, 8'h44, 8'h44};
        vecs[4]  = '{3, 2'd0, 8'hA0, 8'hB1, 8'hC2, 8'h00, 8'hA0};
        vecs[5]  = '{3, 2'd1, 8'hA0, 8'hB1, 8'hC2, 8'h00, 8'hB1};
        vecs[6]  = '{3, 2'd2, 8'hA0, 8'hB1, 8'hC2, 8'h00, 8'hC2};
        vecs[7]  = '{3, 2'd3, 8'hA0, 8'hB1, 8'hC2, 8'h00, 8'hC2};
        vecs[8]  = '{3, 2'd3, 8'hA0, 8'hB1, 8'hC2, 8'hFF, 8'hC2};
        vecs[9]  = '{3, 2'd1, 8'hA0, 8'hB1, 8'hC2, 8'hFF, 8'hB1};
        vecs[10] = '{2, 2'b00, 8'h5A, 8'h00, 8'h77, 8'h99, 8'h5A};
        vecs[11] = '{2, 2'b10, 8'h5A, 8'h00, 8'h77, 8'h99, 8'h5A};
        vecs[12] = '{2, 2'b01, 8'h5A, 8'h00, 8'h77, 8'h99, 8'h00};
        vecs[13] = '{2, 2'b11, 8'h5A, 8'h00, 8'h77, 8'h99, 8'h00};

        // Registered reset behaviour: rst is held for two edges.
        rst = 1'b1; s = 2'd2; a0 = 8'h11; a1 = 8'h22; a2 = 8'h33; a3 = 8'h44;
        tick(); tick();
        check("reset_r4", o_r4, 0);
        check("reset_r3", o_r3, 0);
        check("reset_r2", o_r2, 0);
        rst = 1'b0;
        #1;
        check("no_early_data_r4", o_r4, 0);
        tick();
        check("release_r4", o_r4, 38'h33);
        check("release_r3", o_r3, 38'h33);
        check("release_r2", o_r2, 38'h11);
        s = 2'd3;
        tick();
        check("s3_r4", o_r4, 38'h44);
        check("s3_r3", o_r3, 38'h33);
        check("s3_r2", o_r2, 38'h22);
        rst = 1'b1; s = 2'd1;
        tick();
        check("midreset_r4", o_r4, 0);
        check("midreset_r3", o_r3, 0);
        check("midreset_r2", o_r2, 0);
        rst = 1'b0; s = 2'd0;
        tick();
        check("rerelease_r4", o_r4, 38'h11);
        check("rerelease_r2", o_r2, 38'h11);

        // Combinational directed table.
        for (int k = 0; k < 14; k++) begin
            s = vecs[k].s; a0 = vecs[k].i0; a1 = vecs[k].i1; a2 = vecs[k].i2; a3 = vecs[k].i3;
            #1;
            check($sformatf("vec%0d_n%0d_s%0d", k, vecs[k].n, vecs[k].s), comb_out(vecs[k].n), vecs[k].exp);
        end

        // 38-bit walking ones. Unselected inputs carry the complement pattern,
        // so any leakage into the output would be visible.
        for (int k = 0; k < 4; k++) begin
            for (int b = 0; b < 38; b++) begin
                one = 38'd1 << b;
                w0 = (k == 0) ? one : ~one;
                w1 = (k == 1) ? one : ~one;
                w2 = (k == 2) ? one : ~one;
                w3 = (k == 3) ? one : ~one;
                ws = 2'(k);
                #1;
                check($sformatf("walk_i%0d_b%0d", k, b), o_w, one);
            end
        end

        // Randomized: comb outputs checked immediately, registered after the edge.
        tick();
        for (int c = 0; c < 1000; c++) begin
            s = 2'($urandom_range(0, 3));
            a0 = 8'($urandom); a1 = 8'($urandom); a2 = 8'($urandom); a3 = 8'($urandom);
            #1;
            check($sformatf("rnd%0d_c4", c), o_c4, model(4, s, a0, a1, a2, a3));
            check($sformatf("rnd%0d_c3", c), o_c3, model(3, s, a0, a1, a2, a3));
            check($sformatf("rnd%0d_c2", c), o_c2, model(2, s, a0, a1, a2, a3));
            exp_r4 = model(4, s, a0, a1, a2, a3);
            exp_r3 = model(3, s, a0, a1, a2, a3);
            exp_r2 = model(2, s, a0, a1, a2, a3);
            tick();
            check($sformatf("rnd%0d_r4", c), o_r4, exp_r4);
            check($sformatf("rnd%0d_r3", c), o_r3, exp_r3);
            check($sformatf("rnd%0d_r2", c), o_r2, exp_r2);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
